// File: rtl/params_pkg.sv
// Shared constants and types for the BRAM loaders.
// Holds the weight/A BRAM sizes and the stream-writer defaults.
package params_pkg;

  localparam int WEIGHT_BRAM_DATA_W = 8;
  localparam int WEIGHT_BRAM_DEPTH  = 1024;
  localparam int A_BRAM_DATA_W      = 8;
  localparam int A_BRAM_DEPTH       = 256;

  localparam int BSW_DATA_WIDTH = 8;
  localparam int BSW_DEPTH      = 256;
  localparam int BSW_ADDR_W     = $clog2(BSW_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    FLUSH,
    DONE
  } bram_wr_state_t;

endpackage

// File: rtl/bram_stream_writer.sv
// Streams DEPTH words from a valid/ready source into BRAM port A.
// Define BRAM_STREAM_WRITER_LAST_CHK_EN to check s_last_i framing.
module bram_stream_writer
  import params_pkg::*;
#(
  parameter int DATA_WIDTH = BSW_DATA_WIDTH,
  parameter int DEPTH      = BSW_DEPTH,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  clear_i,
  input  logic                  s_valid_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_last_i,
  output logic                  s_ready_o,
  output logic                  BRAM_ena,
  output logic                  BRAM_wea,
  output logic [ADDR_W-1:0]     BRAM_addra,
  output logic [DATA_WIDTH-1:0] BRAM_dina,
  output logic                  load_done_o,
  output logic                  err_o
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  bram_wr_state_t state_q, state_d;
  logic [ADDR_W-1:0]     cnt_q, cnt_d;
  logic                  ena_q, ena_d;
  logic                  wea_q, wea_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  done_q, done_d;
  logic                  early_q, early_d;
  logic                  accept;
  logic                  at_end;

  assign s_ready_o   = (state_q == WRITE);
  assign accept      = s_valid_i && s_ready_o;
  assign at_end      = (cnt_q == LAST_IDX);
  assign BRAM_ena    = ena_q;
  assign BRAM_wea    = wea_q;
  assign BRAM_addra  = addr_q;
  assign BRAM_dina   = din_q;
  assign load_done_o = done_q;

  // Next state, counter and registered BRAM write request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ena_d   = 1'b0;
    wea_d   = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
    early_d = early_q;
    if (clear_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      early_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d = WRITE;
            cnt_d   = '0;
            early_d = 1'b0;
          end
        end
        WRITE: begin
          if (accept) begin
            ena_d  = 1'b1;
            wea_d  = 1'b1;
            addr_d = cnt_q;
            din_d  = s_data_i;
            if (at_end) begin
              state_d = FLUSH;
            end else begin
              cnt_d = cnt_q + 1'b1;
`ifdef BRAM_STREAM_WRITER_LAST_CHK_EN
              if (s_last_i) begin
                state_d = FLUSH;
                early_d = 1'b1;
              end
`endif
            end
          end
        end
        FLUSH: state_d = early_q ? IDLE : DONE;
        DONE:  state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
    done_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ena_q   <= 1'b0;
      wea_q   <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      done_q  <= 1'b0;
      early_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ena_q   <= ena_d;
      wea_q   <= wea_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      done_q  <= done_d;
      early_q <= early_d;
    end
  end

`ifdef BRAM_STREAM_WRITER_LAST_CHK_EN
  logic err_q, err_d;

  // Sticky framing error: last too early, or missing on the final word.
  always_comb begin
    err_d = err_q;
    if (clear_i) begin
      err_d = 1'b0;
    end else if (accept && (at_end != s_last_i)) begin
      err_d = 1'b1;
    end
  end

  // Error flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_o = err_q;
`else
  logic unused_last;
  assign unused_last = s_last_i;
  assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_bram_stream_writer.sv
// Directed bench for bram_stream_writer at DEPTH=4, DATA_WIDTH=8.
// Expected writes are queued at accept and checked on port A.
module tb_bram_stream_writer;

  localparam int DW = 8;
  localparam int DP = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic          clear_i = 1'b0;
  logic          s_valid_i = 1'b0;
  logic [DW-1:0] s_data_i = '0;
  logic          s_last_i = 1'b0;
  logic          s_ready_o;
  logic          BRAM_ena;
  logic          BRAM_wea;
  logic [AW-1:0] BRAM_addra;
  logic [DW-1:0] BRAM_dina;
  logic          load_done_o;
  logic          err_o;

  bram_stream_writer #(
    .DATA_WIDTH(DW),
    .DEPTH     (DP),
    .ADDR_W    (AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .clear_i    (clear_i),
    .s_valid_i  (s_valid_i),
    .s_data_i   (s_data_i),
    .s_last_i   (s_last_i),
    .s_ready_o  (s_ready_o),
    .BRAM_ena   (BRAM_ena),
    .BRAM_wea   (BRAM_wea),
    .BRAM_addra (BRAM_addra),
    .BRAM_dina  (BRAM_dina),
    .load_done_o(load_done_o),
    .err_o      (err_o)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            cyc;
  } wr_t;

  wr_t           q[$];
  int            ncmp = 0;
  int            nerr = 0;
  int            cyc = 0;
  int            exp_addr = 0;
  logic [DW-1:0] mem_act[DP];
  logic [DW-1:0] mem_exp[DP];
  logic          seen[DP];

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Port-A monitor: every write must match the head of the queue.
  always @(negedge clk) begin
    if (BRAM_wea || BRAM_ena) begin
      if (q.size() == 0) begin
        ncmp++;
        nerr++;
        $error("FAIL unexpected_write: observed addr %0h data %0h expected none",
               BRAM_addra, BRAM_dina);
      end else begin
        wr_t e;
        e = q.pop_front();
        chk("wr_addr", 32'(BRAM_addra), 32'(e.a));
        chk("wr_data", 32'(BRAM_dina), 32'(e.d));
        chk("wr_cycle", 32'(cyc), 32'(e.cyc));
        chk("wr_ena_wea", {31'd0, BRAM_ena & BRAM_wea}, 32'd1);
      end
      mem_act[BRAM_addra] = BRAM_dina;
      seen[BRAM_addra] = 1'b1;
    end
  end

  task automatic clr_mem();
    for (int i = 0; i < DP; i++) begin
      mem_act[i] = '0;
      mem_exp[i] = '0;
      seen[i] = 1'b0;
    end
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    exp_addr = 0;
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
  endtask

  // Present one beat at a negedge and hold it until accepted.
  task automatic send(logic [DW-1:0] d, logic last);
    bit ok = 1'b0;
    s_valid_i = 1'b1;
    s_data_i = d;
    s_last_i = last;
    for (int t = 0; t < 20 && !ok; t++) begin
      if (s_ready_o) begin
        wr_t e;
        e.a = AW'(exp_addr);
        e.d = d;
        e.cyc = cyc + 1;
        q.push_back(e);
        mem_exp[exp_addr] = d;
        exp_addr++;
        ok = 1'b1;
      end
      @(negedge clk);
    end
    s_valid_i = 1'b0;
    s_last_i = 1'b0;
    if (!ok) begin
      ncmp++;
      nerr++;
      $error("FAIL send_timeout: observed ready 0 expected ready 1");
    end
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_mem(string tag);
    for (int i = 0; i < DP; i++)
      chk(tag, 32'(mem_act[i]), 32'(mem_exp[i]));
  endtask

  initial begin
    clr_mem();
    // Reset state.
    idle(2);
    chk("rst_ready", 32'(s_ready_o), 32'd0);
    chk("rst_bram", {28'd0, BRAM_ena, BRAM_wea, BRAM_addra == 0, BRAM_dina == 0},
        32'h3);
    chk("rst_done_err", {30'd0, load_done_o, err_o}, 32'd0);
    rst_n = 1'b1;
    idle(2);
    chk("idle_ready", 32'(s_ready_o), 32'd0);

    // Back-to-back full load.
    pulse_start();
    chk("write_ready", 32'(s_ready_o), 32'd1);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b1);
    chk("done_at_last_wr", 32'(load_done_o), 32'd0);
    idle(1);
    chk("done_after_last", 32'(load_done_o), 32'd1);
    chk("err_ok", 32'(err_o), 32'd0);
    chk("done_ready", 32'(s_ready_o), 32'd0);
    chk("q_empty1", 32'(q.size()), 32'd0);
    chk_mem("mem_b2b");
    pulse_start();
    idle(1);
    chk("start_ign_done", {30'd0, load_done_o, s_ready_o}, 32'h2);

    // Clear in DONE, then reload with gaps between beats.
    pulse_clear();
    chk("clear_done", 32'(load_done_o), 32'd0);
    clr_mem();
    pulse_start();
    send(8'h11, 1'b0);
    idle(1);
    send(8'h22, 1'b0);
    idle(1);
    send(8'h33, 1'b0);
    idle(1);
    send(8'h44, 1'b1);
    idle(2);
    chk("gap_done", 32'(load_done_o), 32'd1);
    chk("gap_q_empty", 32'(q.size()), 32'd0);
    chk_mem("mem_gap");

    // Clear collides with the third accepted beat.
    pulse_clear();
    clr_mem();
    pulse_start();
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    chk("pre_clr_ready", 32'(s_ready_o), 32'd1);
    s_valid_i = 1'b1;
    s_data_i = 8'h33;
    clear_i = 1'b1;
    @(negedge clk);
    s_valid_i = 1'b0;
    clear_i = 1'b0;
    chk("clr_no_wea", 32'(BRAM_wea), 32'd0);
    chk("clr_idle", 32'(s_ready_o), 32'd0);
    idle(3);
    chk("clr_no_done", 32'(load_done_o), 32'd0);
    chk("clr_no_addr2", 32'(seen[2]), 32'd0);
    chk("clr_q_empty", 32'(q.size()), 32'd0);

    // Early s_last_i on the second beat.
    clr_mem();
    pulse_start();
    send(8'h11, 1'b0);
    send(8'h22, 1'b1);
`ifdef BRAM_STREAM_WRITER_LAST_CHK_EN
    idle(2);
    chk("early_err", 32'(err_o), 32'd1);
    chk("early_done", 32'(load_done_o), 32'd0);
    chk("early_idle", 32'(s_ready_o), 32'd0);
    chk("early_no_addr2", 32'(seen[2]), 32'd0);
`else
    chk("nochk_ready", 32'(s_ready_o), 32'd1);
    send(8'h33, 1'b0);
    send(8'h44, 1'b1);
    idle(1);
    chk("nochk_done", 32'(load_done_o), 32'd1);
    chk("nochk_err", 32'(err_o), 32'd0);
`endif
    chk("early_q_empty", 32'(q.size()), 32'd0);
    chk_mem("mem_early");

    // Missing s_last_i on the final word.
    pulse_clear();
    chk("clr_err", 32'(err_o), 32'd0);
    clr_mem();
    pulse_start();
    send(8'h55, 1'b0);
    send(8'h66, 1'b0);
    send(8'h77, 1'b0);
    send(8'h88, 1'b0);
    idle(1);
    chk("nolast_done", 32'(load_done_o), 32'd1);
`ifdef BRAM_STREAM_WRITER_LAST_CHK_EN
    chk("nolast_err", 32'(err_o), 32'd1);
`else
    chk("nolast_err", 32'(err_o), 32'd0);
`endif
    chk_mem("mem_nolast");

    // Asynchronous reset mid-load.
    pulse_clear();
    clr_mem();
    pulse_start();
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    s_valid_i = 1'b1;
    s_data_i = 8'h33;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_outs", {24'd0, s_ready_o, BRAM_ena, BRAM_wea, load_done_o,
                      err_o, 1'b0, BRAM_addra != 0}, 32'd0);
    chk("arst_dina", 32'(BRAM_dina), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(3);
    chk("post_rst_ready", 32'(s_ready_o), 32'd0);
    chk("post_rst_seen2", 32'(seen[2]), 32'd0);
    s_valid_i = 1'b0;
    clr_mem();
    pulse_start();
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b1);
    idle(1);
    chk("reload_done", 32'(load_done_o), 32'd1);
    chk("final_q_empty", 32'(q.size()), 32'd0);
    chk_mem("mem_reload");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
